// File: rtl/sort_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : sort_pkg                                                          |
// | Brief  : Shared types and constants for the bubble-sort pass controller:   |
// |          FSM state enumeration, default sort geometry, pass-counter width. |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
package sort_pkg;

  // Default word width and numbers per sort
  localparam int DEF_N_BITS    = 8;
  localparam int DEF_K_NUMBERS = 8;

  // Width of the completed-pass counter
  localparam int PASS_CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/sort_pass_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : sort_pass_ctrl                                                    |
// | Brief  : Sequences compare passes of a bubble sort. Each pass walks the    |
// |          compare index 0..K_NUMBERS-2 (RUN), then idles two cycles (GAP)   |
// |          while the pass monitor decides whether the data is sorted.        |
// |          The sort ends on interrupt_i or after MAX_PASSES passes (timeout).|
// | Ports  : clk, rst      - clock, synchronous active-high reset              |
// |          start_i       - begin a sort (honoured in IDLE only)              |
// |          cmp_swap_i    - comparator swapped at current index               |
// |          interrupt_i   - pass monitor reports sort complete                |
// |          ack_i         - host acknowledge of irq_o                         |
// |          run_o, swap_o, idx_o - pass framing, swap flag, compare index     |
// |          busy_o, pass_cnt_o, irq_o, err_o - status                         |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module sort_pass_ctrl
  import sort_pkg::*;
#(
  parameter int N_BITS     = DEF_N_BITS,
  parameter int K_NUMBERS  = DEF_K_NUMBERS,
  parameter int MAX_PASSES = K_NUMBERS + 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start_i,
  input  logic                         cmp_swap_i,
  input  logic                         interrupt_i,
  input  logic                         ack_i,
  output logic                         run_o,
  output logic                         swap_o,
  output logic [$clog2(K_NUMBERS)-1:0] idx_o,
  output logic                         busy_o,
  output logic [PASS_CNT_W-1:0]        pass_cnt_o,
  output logic                         irq_o,
  output logic                         err_o
);

  localparam int                     IDX_W      = $clog2(K_NUMBERS);
  localparam logic [IDX_W-1:0]       LAST_IDX   = IDX_W'(K_NUMBERS - 2);
  localparam logic [PASS_CNT_W-1:0]  PASS_LIMIT = PASS_CNT_W'(MAX_PASSES);

  // The controller carries no datapath; N_BITS only has to be sane.
  if (K_NUMBERS < 2 || N_BITS < 1) begin : g_param_check
    $error("sort_pass_ctrl: requires K_NUMBERS >= 2 and N_BITS >= 1");
  end

  state_t                  state, state_nxt;
  logic [IDX_W-1:0]        idx, idx_nxt;
  logic                    gap_second, gap_second_nxt;
  logic [PASS_CNT_W-1:0]   pass_cnt, pass_cnt_nxt;
  logic                    sticky, sticky_nxt;
  logic                    err, err_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      idx        <= '0;
      gap_second <= 1'b0;
      pass_cnt   <= '0;
      sticky     <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      gap_second <= gap_second_nxt;
      pass_cnt   <= pass_cnt_nxt;
      sticky     <= sticky_nxt;
      err        <= err_nxt;
    end
  end

  // idx_nxt defaults to 0, so the index only advances while staying in RUN
  // and is already 0 whenever RUN is (re)entered.
  always_comb begin
    state_nxt      = state;
    idx_nxt        = '0;
    gap_second_nxt = 1'b0;
    pass_cnt_nxt   = pass_cnt;
    sticky_nxt     = sticky;
    err_nxt        = err;

    unique case (state)
      ST_IDLE: begin
        if (start_i) begin
          state_nxt    = ST_RUN;
          pass_cnt_nxt = '0;
          sticky_nxt   = 1'b0;
        end
      end

      ST_RUN: begin
        sticky_nxt = sticky | cmp_swap_i;
        if (interrupt_i) begin
          // Pass abandoned: no pass count for it.
          state_nxt = ST_DONE;
          err_nxt   = 1'b0;
        end else if (idx == LAST_IDX) begin
          state_nxt = ST_GAP;
          if (pass_cnt != '1) begin
            pass_cnt_nxt = pass_cnt + PASS_CNT_W'(1);
          end
        end else begin
          idx_nxt = idx + IDX_W'(1);
        end
      end

      ST_GAP: begin
        if (interrupt_i) begin
          state_nxt = ST_DONE;
          err_nxt   = 1'b0;
        end else if (gap_second) begin
          if (pass_cnt >= PASS_LIMIT) begin
            state_nxt = ST_DONE;
            err_nxt   = 1'b1;
          end else begin
            state_nxt  = ST_RUN;
            sticky_nxt = 1'b0;
          end
        end else begin
          gap_second_nxt = 1'b1;
        end
      end

      ST_DONE: begin
        // ack wins over start: a sort never restarts straight from DONE.
        if (ack_i) begin
          state_nxt  = ST_IDLE;
          err_nxt    = 1'b0;
          sticky_nxt = 1'b0;
        end
      end

      default: state_nxt = ST_IDLE;
    endcase
  end

  assign run_o      = (state == ST_RUN);
  // Combinational term makes a swap on the last compare visible before the
  // run_o falling edge.
  assign swap_o     = sticky | (cmp_swap_i & run_o);
  assign idx_o      = idx;
  assign busy_o     = (state != ST_IDLE);
  assign pass_cnt_o = pass_cnt;
  assign irq_o      = (state == ST_DONE);
  assign err_o      = err;

endmodule
`default_nettype wire

// File: tb/tb_sort_pass_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_sort_pass_ctrl                                                 |
// | Brief  : Scoreboard bench for sort_pass_ctrl (K_NUMBERS=8). A sort plan   |
// |          (interrupt point, swap pattern, DONE wait, optional reset) is     |
// |          expanded into per-cycle expected outputs; a monitor compares.    |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tb_sort_pass_ctrl;

  localparam int K     = 8;
  localparam int MAXP  = K + 2;
  localparam int IDX_W = $clog2(K);

  logic             clk = 1'b0;
  logic             rst, start_i, cmp_swap_i, interrupt_i, ack_i;
  logic             run_o, swap_o, busy_o, irq_o, err_o;
  logic [IDX_W-1:0] idx_o;
  logic [15:0]      pass_cnt_o;

  sort_pass_ctrl #(.N_BITS(8), .K_NUMBERS(K), .MAX_PASSES(MAXP)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .cmp_swap_i(cmp_swap_i),
    .interrupt_i(interrupt_i), .ack_i(ack_i), .run_o(run_o), .swap_o(swap_o),
    .idx_o(idx_o), .busy_o(busy_o), .pass_cnt_o(pass_cnt_o), .irq_o(irq_o),
    .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        run, swap, chk_swap, chk_idx, busy, irq, err;
    int          idx;
    int          pcnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   model_pcnt = 0;

  function automatic exp_t mk(input logic run, swap, chk_swap, chk_idx,
                              input int idx, input logic busy, irq, err,
                              input int pcnt);
    exp_t e;
    e.run = run; e.swap = swap; e.chk_swap = chk_swap; e.chk_idx = chk_idx;
    e.idx = idx; e.busy = busy; e.irq = irq; e.err = err; e.pcnt = pcnt;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", nm, act, req, $time);
    end
  endtask

  // Monitor: compare the record issued for this cycle mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("run_o",      32'(run_o),      32'(mon_e.run));
      chk("busy_o",     32'(busy_o),     32'(mon_e.busy));
      chk("irq_o",      32'(irq_o),      32'(mon_e.irq));
      chk("err_o",      32'(err_o),      32'(mon_e.err));
      chk("pass_cnt_o", 32'(pass_cnt_o), 32'(mon_e.pcnt));
      if (mon_e.chk_swap) chk("swap_o", 32'(swap_o), 32'(mon_e.swap));
      if (mon_e.chk_idx)  chk("idx_o",  32'(idx_o),  32'(mon_e.idx));
    end
  end

  task automatic step(input logic r, st, cs, it, ak, input exp_t e);
    @(posedge clk); #1;
    rst = r; start_i = st; cmp_swap_i = cs; interrupt_i = it; ack_i = ak;
    exp_q.push_back(e);
  endtask

  function automatic exp_t idle_e();
    return mk(0, 0, 1, 1, 0, 0, 0, 0, model_pcnt);
  endfunction

  // int_pass: pass carrying interrupt_i (0 = never -> timeout).
  // int_where: 0..K-2 = RUN index, K-1 / K = first / second GAP cycle.
  // swap_mode: 0 random swaps, 1 swap only on the last compare.
  task automatic run_sort(input int int_pass, input int int_where,
                          input int swap_mode, input bit do_reset,
                          input int done_wait, input bit start_with_ack,
                          input int n_idle);
    bit done = 0;
    bit err  = 0;
    bit sw, cs, it;
    int p;
    for (int i = 0; i < n_idle; i++)
      step(0, 0, 1'($urandom_range(0, 1)), 0, 0, idle_e());
    step(0, 1, 1'($urandom_range(0, 1)), 0, 0, idle_e());
    model_pcnt = 0;
    p = 0;
    while (!done) begin
      p++;
      sw = 0;
      for (int j = 0; j <= K - 2; j++) begin
        cs = (swap_mode == 1) ? (j == K - 2) : ($urandom_range(0, 3) == 0);
        it = (p == int_pass) && (int_where == j);
        sw = sw | cs;
        if (do_reset && p == 2 && j == 3) begin
          step(1, 1'($urandom_range(0, 1)), cs, 0, 0,
               mk(1, sw, 1, 1, j, 1, 0, 0, p - 1));
          model_pcnt = 0;
          step(0, 0, 0, 0, 0, idle_e());
          return;
        end
        step(0, 1'($urandom_range(0, 1)), cs, it, 0,
             mk(1, sw, 1, 1, j, 1, 0, 0, p - 1));
        if (it) begin done = 1; break; end
      end
      if (done) break;
      model_pcnt = (p > 65535) ? 65535 : p;
      for (int g = 0; g < 2; g++) begin
        it = (p == int_pass) && (int_where == K - 1 + g);
        step(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), it, 0,
             mk(0, sw, 1, 0, 0, 1, 0, 0, model_pcnt));
        if (it) begin done = 1; break; end
      end
      if (!done && model_pcnt >= MAXP) begin done = 1; err = 1; end
    end
    for (int w = 0; w < done_wait; w++)
      step(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 0,
           mk(0, 0, 0, 0, 0, 1, 1, err, model_pcnt));
    step(0, start_with_ack, 0, 0, 1, mk(0, 0, 0, 0, 0, 1, 1, err, model_pcnt));
    // The cycle after ack must be IDLE even if start_i came with ack.
    step(0, 0, 0, 0, 0, idle_e());
  endtask

  initial begin
    rst = 1; start_i = 0; cmp_swap_i = 0; interrupt_i = 0; ack_i = 0;
    repeat (3) @(posedge clk);
    // Reset state
    step(0, 0, 0, 0, 0, idle_e());
    // Interrupt in 3rd GAP, no swaps except as random -> 3 passes, err=0
    run_sort(3, K - 1, 0, 0, 2, 0, 1);
    // Swap only at the last compare; interrupt in 2nd GAP cycle of pass 2
    run_sort(2, K, 1, 0, 1, 0, 0);
    // Timeout: no interrupt -> 10 passes, err=1
    run_sort(0, 0, 0, 0, 3, 0, 2);
    // Reset at idx 3 of pass 2, then restart from pass_cnt 0
    run_sort(0, 0, 0, 1, 0, 0, 1);
    run_sort(1, 4, 0, 0, 1, 1, 0);
    // Interrupt in the final GAP cycle at the pass limit beats timeout
    run_sort(MAXP, K, 0, 0, 0, 1, 1);
    // Interrupt in RUN on the last compare abandons the pass
    run_sort(2, K - 2, 0, 0, 0, 0, 0);
    // Randomized sorts
    for (int s = 0; s < 20; s++) begin
      run_sort(($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, MAXP)),
               int'($urandom_range(0, K)), 0, ($urandom_range(0, 7) == 0),
               int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               int'($urandom_range(0, 2)));
    end
    step(0, 0, 0, 0, 0, idle_e());
    repeat (2) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_chk++; n_fail++;
      $display("FAIL drain: got %0d pending records, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
